t02_ram_responder: RTL and testbench

RAM-side responder for the t02 memory bus. It services the single-port Ren/Wen/ramaddr/ramstore request stream issued by the team's memory controller and returns ramload with a busy_o handshake. It holds a word-addressed internal memory and inserts a configurable number of wait states, so controller and CPU stall paths can be exercised against realistic latency. It sits directly below the memory controller and replaces the external SRAM in simulation and FPGA bring-up.

---
 rtl/t02_ram_responder.sv | 151 +++++++++++++++
 tb/tb_t02_ram_responder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/t02_ram_responder.sv
// RAM-side responder for the t02 memory bus: word-addressed internal memory behind
// the Ren/Wen/ramaddr/ramstore request stream, with a programmable wait-state delay.
module t02_ram_responder #(
    parameter int          DEPTH    = 256,
    parameter int          LATENCY  = 2,
    parameter logic [31:0] OOR_DATA = 32'hBAD0_BAD0
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        Ren,
    input  logic        Wen,
    input  logic [31:0] ramaddr,
    input  logic [31:0] ramstore,
    output logic [31:0] ramload,
    output logic        busy_o,
    output logic        err_o,
    output logic [1:0]  o_dbg_state
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] CNT_LOAD = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Handshake: a request is valid when exactly one of Ren/Wen is high; it is
    // accepted in IDLE and must be held unchanged in op until busy_o drops for one
    // cycle, after which the controller drops it (DONE never re-captures).
    state_t          r_state;
    logic [3:0]      r_cnt;
    logic            r_op_wr;
    logic [AW-1:0]   r_idx;
    logic            r_oor;
    logic [31:0]     r_wdata;
    logic [31:0]     r_ramload;
    logic [31:0]     r_mem [DEPTH];

    state_t          w_next_state;
    logic [3:0]      w_cnt_next;
    logic            w_rd_req;
    logic            w_wr_req;
    logic            w_capture;
    logic            w_access;
    logic            w_acc_wr;
    logic [AW-1:0]   w_acc_idx;
    logic            w_acc_oor;
    logic [31:0]     w_acc_data;
    logic [AW-1:0]   w_live_idx;
    logic            w_live_oor;
    logic            w_unused;

    assign w_rd_req   = Ren & ~Wen;
    assign w_wr_req   = Wen & ~Ren;
    assign w_live_idx = ramaddr[AW+1:2];
    assign w_live_oor = |ramaddr[31:AW+2];
    // Byte offset within the word is deliberately ignored.
    assign w_unused   = &{1'b0, ramaddr[1:0]};

    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        w_capture    = 1'b0;
        w_access     = 1'b0;
        w_acc_wr     = r_op_wr;
        w_acc_idx    = r_idx;
        w_acc_oor    = r_oor;
        w_acc_data   = r_wdata;
        case (r_state)
            S_IDLE: begin
                if (w_rd_req || w_wr_req) begin
                    w_capture = 1'b1;
                    if (LATENCY == 0) begin
                        w_access     = 1'b1;
                        w_acc_wr     = w_wr_req;
                        w_acc_idx    = w_live_idx;
                        w_acc_oor    = w_live_oor;
                        w_acc_data   = ramstore;
                        w_next_state = S_DONE;
                    end else begin
                        w_cnt_next   = CNT_LOAD;
                        w_next_state = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // Dropping the request or switching op abandons the access.
                if (!(r_op_wr ? w_wr_req : w_rd_req)) begin
                    w_next_state = S_IDLE;
                end else if (r_cnt == 4'd0) begin
                    w_access     = 1'b1;
                    w_next_state = S_DONE;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_op_wr <= 1'b0;
            r_idx   <= '0;
            r_oor   <= 1'b0;
            r_wdata <= 32'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
            if (w_capture) begin
                r_op_wr <= w_wr_req;
                r_idx   <= w_live_idx;
                r_oor   <= w_live_oor;
                r_wdata <= ramstore;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 32'd0;
            end
        end else if (w_access && w_acc_wr && !w_acc_oor) begin
            r_mem[w_acc_idx] <= w_acc_data;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_ramload <= 32'd0;
        end else if (w_access && !w_acc_wr) begin
            r_ramload <= w_acc_oor ? OOR_DATA : r_mem[w_acc_idx];
        end
    end

    assign ramload     = r_ramload;
    assign busy_o      = (r_state != S_DONE);
    assign err_o       = (r_state == S_DONE) & r_oor;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_t02_ram_responder.sv
// Directed bench for t02_ram_responder: transaction-level model checked every cycle,
// plus literal expectations for latency, read data and error flags.
module tb_t02_ram_responder;

    localparam int          DEPTH    = 256;
    localparam int          LATENCY  = 2;
    localparam logic [31:0] OOR_DATA = 32'hBAD0_BAD0;

    // clock / reset
    logic        CLK = 1'b0;
    logic        nRST;
    logic        Ren;
    logic        Wen;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic        busy_o;
    logic        err_o;
    logic [1:0]  o_dbg_state;

    always #5 CLK = ~CLK;

    t02_ram_responder #(
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY),
        .OOR_DATA(OOR_DATA)
    ) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .Ren        (Ren),
        .Wen        (Wen),
        .ramaddr    (ramaddr),
        .ramstore   (ramstore),
        .ramload    (ramload),
        .busy_o     (busy_o),
        .err_o      (err_o),
        .o_dbg_state(o_dbg_state)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Transaction-level model: a request accepted at edge s completes at edge
    // s+LATENCY if still held with the same op; the next cycle is the ready cycle.
    logic [31:0] mem_m [DEPTH];
    logic [31:0] exp_ramload = 32'd0;
    bit          m_pend = 1'b0;
    bit          m_done = 1'b0;
    bit          m_is_wr = 1'b0;
    bit          m_oor = 1'b0;
    int          m_idx = 0;
    logic [31:0] m_data = 32'd0;
    int          edge_no = 0;
    int          m_start = 0;
    bit          m_rd_v;
    bit          m_wr_v;

    initial begin
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'd0;
    end

    task automatic m_access();
        if (m_is_wr) begin
            if (!m_oor) mem_m[m_idx] = m_data;
        end else begin
            exp_ramload = m_oor ? OOR_DATA : mem_m[m_idx];
        end
    endtask

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'd0;
            exp_ramload = 32'd0;
            m_pend = 1'b0;
            m_done = 1'b0;
            m_oor  = 1'b0;
        end else begin
            m_rd_v = Ren && !Wen;
            m_wr_v = Wen && !Ren;
            if (m_done) begin
                m_done = 1'b0;
            end else if (m_pend) begin
                if (!(m_is_wr ? m_wr_v : m_rd_v)) begin
                    m_pend = 1'b0;
                end else if (edge_no - m_start == LATENCY) begin
                    m_access();
                    m_pend = 1'b0;
                    m_done = 1'b1;
                end
            end else if (m_rd_v || m_wr_v) begin
                m_is_wr = m_wr_v;
                m_oor   = (ramaddr >= 32'(DEPTH * 4));
                m_idx   = int'((ramaddr % 32'(DEPTH * 4)) / 32'd4);
                m_data  = ramstore;
                m_start = edge_no;
                if (LATENCY == 0) begin
                    m_access();
                    m_done = 1'b1;
                end else begin
                    m_pend = 1'b1;
                end
            end
            edge_no++;
        end
    end

    // scoreboard: every cycle, compare against the model; log ready pulses
    int cyc = 0;
    int pulse_q[$];

    always @(negedge CLK) begin
        cyc++;
        chk("busy_o", 32'(busy_o), 32'(!m_done));
        chk("err_o", 32'(err_o), 32'(m_done && m_oor));
        chk("ramload", ramload, exp_ramload);
        chk("state", 32'(o_dbg_state), m_done ? 32'd2 : (m_pend ? 32'd1 : 32'd0));
        if (nRST && busy_o === 1'b0) pulse_q.push_back(cyc);
    end

    // driver: hold a request until ready, then drop to the idle encoding
    task automatic run_req(input string nm, input logic ren, input logic wen,
                           input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] rd, output logic er);
        int lat;
        Ren = ren; Wen = wen; ramaddr = a; ramstore = d;
        lat = 0; rd = 32'hxxxx_xxxx; er = 1'bx;
        for (int i = 1; i <= 20; i++) begin
            @(posedge CLK); #1;
            if (busy_o === 1'b0) begin
                lat = i; rd = ramload; er = err_o;
                break;
            end
        end
        Ren = 1'b1; Wen = 1'b1;
        chk({nm, "_latency"}, 32'(lat), 32'd3);
        @(posedge CLK); #1;
    endtask

    logic [31:0] rd;
    logic        er;
    int          n0;

    initial begin
        Ren = 1'b1; Wen = 1'b1; ramaddr = 32'd0; ramstore = 32'd0; nRST = 1'b0;
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;
        pulse_q.delete();
        repeat (10) @(posedge CLK);
        #1;
        chk("idle_pulses", 32'(pulse_q.size()), 32'd0);
        chk("idle_busy", 32'(busy_o), 32'd1);
        chk("idle_ramload", ramload, 32'd0);
        chk("idle_err", 32'(err_o), 32'd0);
        chk("idle_state", 32'(o_dbg_state), 32'd0);

        run_req("wr10", 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, rd, er);
        chk("wr10_err", 32'(er), 32'd0);
        chk("wr10_ramload_kept", rd, 32'd0);
        run_req("rd10", 1'b1, 1'b0, 32'h10, 32'h0, rd, er);
        chk("rd10_data", rd, 32'hDEAD_BEEF);
        chk("rd10_err", 32'(er), 32'd0);
        run_req("rd13", 1'b1, 1'b0, 32'h13, 32'h0, rd, er);
        chk("rd13_data", rd, 32'hDEAD_BEEF);

        run_req("wr3fc", 1'b0, 1'b1, 32'h3FC, 32'h1122_3344, rd, er);
        chk("wr3fc_err", 32'(er), 32'd0);
        run_req("rd3fc", 1'b1, 1'b0, 32'h3FC, 32'h0, rd, er);
        chk("rd3fc_data", rd, 32'h1122_3344);

        run_req("rd400", 1'b1, 1'b0, 32'h400, 32'h0, rd, er);
        chk("rd400_data", rd, 32'hBAD0_BAD0);
        chk("rd400_err", 32'(er), 32'd1);
        run_req("wr400", 1'b0, 1'b1, 32'h400, 32'h1234, rd, er);
        chk("wr400_err", 32'(er), 32'd1);
        run_req("rd0", 1'b1, 1'b0, 32'h0, 32'h0, rd, er);
        chk("rd0_data", rd, 32'd0);
        chk("rd0_err", 32'(er), 32'd0);

        // abort: write withdrawn one cycle after capture
        n0 = pulse_q.size();
        Ren = 1'b0; Wen = 1'b1; ramaddr = 32'h20; ramstore = 32'h55;
        @(posedge CLK); #1;
        Ren = 1'b0; Wen = 1'b0;
        repeat (6) @(posedge CLK);
        #1;
        chk("abort_no_pulse", 32'(pulse_q.size()), 32'(n0));
        Ren = 1'b1; Wen = 1'b1;
        run_req("rd20", 1'b1, 1'b0, 32'h20, 32'h0, rd, er);
        chk("rd20_data", rd, 32'd0);

        // held read across DONE: one pulse per capture, spaced LATENCY+2
        run_req("wr4", 1'b0, 1'b1, 32'h4, 32'hCAFE_F00D, rd, er);
        pulse_q.delete();
        Ren = 1'b1; Wen = 1'b0; ramaddr = 32'h4;
        repeat (8) @(posedge CLK);
        #1;
        Ren = 1'b1; Wen = 1'b1;
        chk("held_pulses", 32'(pulse_q.size()), 32'd2);
        if (pulse_q.size() == 2) chk("held_spacing", 32'(pulse_q[1] - pulse_q[0]), 32'd4);
        chk("held_data", ramload, 32'hCAFE_F00D);
        repeat (3) @(posedge CLK);
        #1;
        chk("held_no_extra", 32'(pulse_q.size()), 32'd2);

        // reset during WAIT discards the write and clears memory
        Ren = 1'b0; Wen = 1'b1; ramaddr = 32'h8; ramstore = 32'hA5A5_A5A5;
        @(posedge CLK); #1;
        chk("midwait_state", 32'(o_dbg_state), 32'd1);
        nRST = 1'b0;
        #1;
        chk("midwait_rst_busy", 32'(busy_o), 32'd1);
        chk("midwait_rst_ramload", ramload, 32'd0);
        Ren = 1'b1; Wen = 1'b1;
        @(posedge CLK); #1;
        nRST = 1'b1;
        run_req("rd8", 1'b1, 1'b0, 32'h8, 32'h0, rd, er);
        chk("rd8_data", rd, 32'd0);
        run_req("rd10_after_rst", 1'b1, 1'b0, 32'h10, 32'h0, rd, er);
        chk("rd10_after_rst_data", rd, 32'd0);

        repeat (2) @(posedge CLK);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
